xilly_loopback_eof: RTL

//  Parametrised successor of the fixed 8/32-bit Xillybus loopback FIFOs. One instance joins
//  one user_w_* write stream to one user_r_* read stream through a synchronous FIFO in bus_clk.

---
 rtl/xilly_pkg.sv | 17 +
 rtl/xilly_sync_fifo.sv | 84 ++++++++
 rtl/xilly_loopback_eof.sv | 109 ++++++++++
 3 files changed

// File: rtl/xilly_pkg.sv
// Shared definitions for the Xillybus loopback FIFO with EOF generation:
// EOF state encoding and the fill-level width helper.
package xilly_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } eof_state_t;

  // Level needs one extra bit so that a completely full FIFO (DEPTH words) is representable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/xilly_sync_fifo.sv
// Standard (non-FWFT) synchronous FIFO with registered full/empty/level flags
// and a registered block-RAM read port.
module xilly_sync_fifo
  import xilly_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
) (
  input  logic                      clk,
  input  logic                      srst,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      wr_accept,
  output logic                      rd_accept
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LVL_W  = lvl_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   wr_ptr_reg;
  logic [ADDR_W:0]   rd_ptr_reg;
  logic [ADDR_W:0]   wr_ptr_next;
  logic [ADDR_W:0]   rd_ptr_next;
  logic              full_reg;
  logic              empty_reg;
  logic [LVL_W-1:0]  level_reg;
  logic [DATA_W-1:0] rd_data_reg;

  assign wr_accept = wr_en && !full_reg;
  assign rd_accept = rd_en && !empty_reg;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (wr_accept) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (rd_accept) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
  end

  // Memory array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      full_reg    <= 1'b0;
      empty_reg   <= 1'b1;
      level_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      empty_reg  <= (wr_ptr_next == rd_ptr_next);
      // Same address, different wrap bit: the writer is a full lap ahead.
      full_reg   <= (wr_ptr_next[ADDR_W] != rd_ptr_next[ADDR_W]) &&
                    (wr_ptr_next[ADDR_W-1:0] == rd_ptr_next[ADDR_W-1:0]);
      level_reg  <= wr_ptr_next - rd_ptr_next;
      if (rd_accept) begin
        rd_data_reg <= mem[rd_ptr_reg[ADDR_W-1:0]];
      end
    end
  end

  assign rd_data = rd_data_reg;
  assign full    = full_reg;
  assign empty   = empty_reg;
  assign level   = level_reg;

endmodule

// File: rtl/xilly_loopback_eof.sv
// Xillybus write-to-read loopback through a synchronous FIFO, with flush on
// both files closed, a sticky overflow flag and EOF once the closed writer's data drains.
module xilly_loopback_eof
  import xilly_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int EOF_EN = 1
) (
  input  logic                      bus_clk,
  input  logic                      srst,
  input  logic                      user_w_wren,
  input  logic [DATA_W-1:0]         user_w_data,
  output logic                      user_w_full,
  input  logic                      user_w_open,
  input  logic                      user_r_rden,
  output logic [DATA_W-1:0]         user_r_data,
  output logic                      user_r_empty,
  output logic                      user_r_eof,
  input  logic                      user_r_open,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      overflow
);

  logic flush;
  logic clr;
  logic wr_accept;
  logic rd_accept;
  logic overflow_reg;
  logic w_open_reg;
  logic w_open_rise;
  logic w_open_fall;

  assign flush = !user_w_open && !user_r_open;
  assign clr   = srst || flush;

  xilly_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (bus_clk),
    .srst      (clr),
    .wr_en     (user_w_wren),
    .wr_data   (user_w_data),
    .rd_en     (user_r_rden),
    .rd_data   (user_r_data),
    .full      (user_w_full),
    .empty     (user_r_empty),
    .level     (level),
    .wr_accept (wr_accept),
    .rd_accept (rd_accept)
  );

  always_ff @(posedge bus_clk) begin
    if (clr) begin
      overflow_reg <= 1'b0;
      w_open_reg   <= 1'b0;
    end else begin
      w_open_reg <= user_w_open;
      if (user_w_wren && user_w_full) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign overflow    = overflow_reg;
  assign w_open_rise = user_w_open && !w_open_reg;
  assign w_open_fall = !user_w_open && w_open_reg;

  generate
    if (EOF_EN != 0) begin : g_eof
      eof_state_t state_reg;
      logic       eof_fire;

      // The pulse must coincide with the first empty cycle of DRAIN, so it is
      // decoded from the state register; a reopen, new write or clear cancels it.
      assign eof_fire = (state_reg == DRAIN) && user_r_empty && !rd_accept &&
                        !wr_accept && !w_open_rise && !clr;

      always_ff @(posedge bus_clk) begin
        if (clr) begin
          state_reg <= IDLE;
        end else begin
          case (state_reg)
            IDLE: begin
              if (w_open_rise) state_reg <= ACTIVE;
            end
            ACTIVE: begin
              if (w_open_fall && user_r_open) state_reg <= DRAIN;
            end
            DRAIN: begin
              if (w_open_rise || wr_accept) state_reg <= ACTIVE;
              else if (eof_fire)            state_reg <= DONE;
            end
            DONE: begin
              if (w_open_rise || wr_accept) state_reg <= ACTIVE;
            end
            default: state_reg <= IDLE;
          endcase
        end
      end

      assign user_r_eof = eof_fire;
    end else begin : g_no_eof
      assign user_r_eof = 1'b0;
    end
  endgenerate

endmodule
